// File: rtl/slot_allocator.sv
// Round-robin allocator for NUM_SLOT resource slots: offers a free index over valid/ready,
// takes releases on a separate port, and reports occupancy.
module slot_allocator #(
   parameter  int NUM_SLOT = 4,
   localparam int IDX_W    = $clog2(NUM_SLOT),
   localparam int CNT_W    = $clog2(NUM_SLOT + 1)
) (
   input  logic                clk_i,
   input  logic                arst_ni,
   input  logic                flush_i,
   output logic                alloc_valid_o,
   output logic [IDX_W-1:0]    alloc_index_o,
   input  logic                alloc_ready_i,
   input  logic                free_valid_i,
   input  logic [IDX_W-1:0]    free_index_i,
   output logic [NUM_SLOT-1:0] busy_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                free_err_o
);

   logic [NUM_SLOT-1:0] r_busy;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_free_err;

   logic [IDX_W-1:0]    w_cand [NUM_SLOT];
   logic [NUM_SLOT-1:0] w_cand_free;
   logic [NUM_SLOT-1:0] w_free_hit_vec;
   logic [NUM_SLOT-1:0] w_busy_next;
   logic [IDX_W-1:0]    w_offer_idx;
   logic [IDX_W-1:0]    w_rr_next;
   logic [CNT_W-1:0]    w_count_next;
   logic                w_full;
   logic                w_free_hit;
   logic                w_alloc_fire;
   logic                w_free_fire;

   // Candidate gi is the slot gi positions after rr_ptr, wrapped explicitly (NUM_SLOT may not be 2^n).
   for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      assign w_sum           = {1'b0, r_rr_ptr} + (IDX_W+1)'(gi);
      assign w_cand[gi]      = (w_sum >= (IDX_W+1)'(NUM_SLOT))
                               ? IDX_W'(w_sum - (IDX_W+1)'(NUM_SLOT))
                               : w_sum[IDX_W-1:0];
      assign w_cand_free[gi] = ~r_busy[w_cand[gi]];
   end

   always_comb begin
      w_offer_idx = '0;
      for (int k = NUM_SLOT - 1; k >= 0; k--) begin
         if (w_cand_free[k]) begin
            w_offer_idx = w_cand[k];
         end
      end
   end

   assign w_full       = (r_count == CNT_W'(NUM_SLOT));
   assign w_alloc_fire = ~w_full & alloc_ready_i;

   for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_free
      assign w_free_hit_vec[gi] = r_busy[gi] && (free_index_i == IDX_W'(gi));
   end
   // A hit implies the index is in range and the slot is busy.
   assign w_free_hit  = |w_free_hit_vec;
   assign w_free_fire = free_valid_i & w_free_hit;

   for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_busy
      assign w_busy_next[gi] = (r_busy[gi] | (w_alloc_fire && (w_offer_idx == IDX_W'(gi))))
                               & ~(w_free_fire && (free_index_i == IDX_W'(gi)));
   end

   assign w_rr_next    = !w_alloc_fire ? r_rr_ptr
                       : (w_offer_idx == IDX_W'(NUM_SLOT - 1)) ? '0
                       : w_offer_idx + IDX_W'(1);
   assign w_count_next = r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_free_fire);

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_busy     <= '0;
         r_rr_ptr   <= '0;
         r_count    <= '0;
         r_free_err <= 1'b0;
      end else if (flush_i) begin
         r_busy     <= '0;
         r_rr_ptr   <= '0;
         r_count    <= '0;
         r_free_err <= 1'b0;
      end else begin
         r_busy     <= w_busy_next;
         r_rr_ptr   <= w_rr_next;
         r_count    <= w_count_next;
         r_free_err <= free_valid_i & ~w_free_hit;
      end
   end

   assign alloc_valid_o = ~w_full;
   assign alloc_index_o = w_offer_idx;
   assign busy_o        = r_busy;
   assign count_o       = r_count;
   assign full_o        = w_full;
   assign empty_o       = (r_count == '0);
   assign free_err_o    = r_free_err;

`ifdef SIMULATION
   initial begin
      if (NUM_SLOT < 2) $fatal(1, "slot_allocator: NUM_SLOT must be >= 2");
   end

   always_ff @(posedge clk_i) begin
      if (arst_ni) begin
         assert ($countones(r_busy) == int'(r_count))
            else $error("slot_allocator: count does not match busy bitmap");
      end
   end
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// Directed test of slot_allocator (NUM_SLOT = 4); offered indices are checked against a queue
// of expected values pushed when each scenario is set up.
module tb_slot_allocator;

   localparam int NUM_SLOT = 4;
   localparam int IDX_W    = 2;
   localparam int CNT_W    = 3;

   logic                clk_i = 1'b0;
   logic                arst_ni;
   logic                flush_i;
   logic                alloc_valid_o;
   logic [IDX_W-1:0]    alloc_index_o;
   logic                alloc_ready_i;
   logic                free_valid_i;
   logic [IDX_W-1:0]    free_index_i;
   logic [NUM_SLOT-1:0] busy_o;
   logic [CNT_W-1:0]    count_o;
   logic                full_o;
   logic                empty_o;
   logic                free_err_o;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];

   slot_allocator #(.NUM_SLOT(NUM_SLOT)) dut (
      .clk_i         (clk_i),
      .arst_ni       (arst_ni),
      .flush_i       (flush_i),
      .alloc_valid_o (alloc_valid_o),
      .alloc_index_o (alloc_index_o),
      .alloc_ready_i (alloc_ready_i),
      .free_valid_i  (free_valid_i),
      .free_index_i  (free_index_i),
      .busy_o        (busy_o),
      .count_o       (count_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .free_err_o    (free_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // Compare the current offer against the oldest expected index.
   task automatic chk_offer(input string tag);
      int e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty, observed=%0d", tag, alloc_index_o);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, 32'(alloc_valid_o), 32'd1);
         chk({tag, "_index"}, 32'(alloc_index_o), 32'(e));
         $display("offer %s: index=%0d expected=%0d", tag, alloc_index_o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   initial begin
      arst_ni       = 1'b0;
      flush_i       = 1'b0;
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b0;
      free_index_i  = '0;
      #2;
      chk("rst_valid", 32'(alloc_valid_o), 32'd1);
      chk("rst_index", 32'(alloc_index_o), 32'd0);
      chk("rst_busy",  32'(busy_o),        32'd0);
      chk("rst_count", 32'(count_o),       32'd0);
      chk("rst_empty", 32'(empty_o),       32'd1);
      chk("rst_full",  32'(full_o),        32'd0);
      chk("rst_err",   32'(free_err_o),    32'd0);
      #10 arst_ni = 1'b1;
      tick();

      // Fill all four slots in order.
      for (int i = 0; i < NUM_SLOT; i++) exp_q.push_back(i);
      alloc_ready_i = 1'b1;
      for (int i = 0; i < NUM_SLOT; i++) begin
         chk_offer("fill");
         tick();
      end
      alloc_ready_i = 1'b0;
      chk("full_full",  32'(full_o),        32'd1);
      chk("full_valid", 32'(alloc_valid_o), 32'd0);
      chk("full_index", 32'(alloc_index_o), 32'd0);
      chk("full_count", 32'(count_o),       32'd4);
      chk("full_busy",  32'(busy_o),        32'hF);
      chk("full_empty", 32'(empty_o),       32'd0);

      // Free slot 1 from full, then reallocate it.
      free_valid_i = 1'b1;
      free_index_i = 2'd1;
      tick();
      free_valid_i = 1'b0;
      chk("free1_busy",  32'(busy_o),  32'hD);
      chk("free1_count", 32'(count_o), 32'd3);
      exp_q.push_back(1);
      chk_offer("refill");
      alloc_ready_i = 1'b1;
      tick();
      alloc_ready_i = 1'b0;
      chk("refill_busy", 32'(busy_o), 32'hF);

      // Round-robin: freed slot 0 is skipped, then the pointer wraps back to 0.
      do_flush();
      exp_q.push_back(0);
      exp_q.push_back(1);
      alloc_ready_i = 1'b1;
      chk_offer("rr_a");
      tick();
      chk_offer("rr_a");
      tick();
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b1;
      free_index_i  = 2'd0;
      tick();
      free_valid_i = 1'b0;
      chk("rr_busy", 32'(busy_o), 32'h2);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      alloc_ready_i = 1'b1;
      chk_offer("rr_b");
      tick();
      chk_offer("rr_b");
      tick();
      alloc_ready_i = 1'b0;
      chk_offer("rr_wrap");
      chk("rr_wrap_busy", 32'(busy_o), 32'hE);

      // Same-cycle allocate (slot 2) and release (slot 0) from busy=0011.
      do_flush();
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      alloc_ready_i = 1'b1;
      chk_offer("sim_a");
      tick();
      chk_offer("sim_a");
      tick();
      chk("sim_pre_busy", 32'(busy_o), 32'h3);
      chk_offer("sim_b");
      free_valid_i = 1'b1;
      free_index_i = 2'd0;
      tick();
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b0;
      chk("sim_busy",  32'(busy_o),  32'h6);
      chk("sim_count", 32'(count_o), 32'd2);

      // Release of a non-busy slot.
      do_flush();
      exp_q.push_back(0);
      alloc_ready_i = 1'b1;
      chk_offer("err_a");
      tick();
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b1;
      free_index_i  = 2'd3;
      tick();
      free_valid_i = 1'b0;
      chk("err_busy",  32'(busy_o),     32'h1);
      chk("err_count", 32'(count_o),    32'd1);
      chk("err_pulse", 32'(free_err_o), 32'd1);
      tick();
      chk("err_clear", 32'(free_err_o), 32'd0);

      // Build busy=1011, then flush with a concurrent alloc and free.
      do_flush();
      alloc_ready_i = 1'b1;
      tick();
      tick();
      tick();
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b1;
      free_index_i  = 2'd2;
      tick();
      free_valid_i = 1'b0;
      exp_q.push_back(3);
      chk_offer("fl_a");
      alloc_ready_i = 1'b1;
      tick();
      chk("fl_pre_busy", 32'(busy_o), 32'hB);
      flush_i      = 1'b1;
      free_valid_i = 1'b1;
      free_index_i = 2'd0;
      tick();
      flush_i       = 1'b0;
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b0;
      chk("fl_busy",  32'(busy_o),        32'd0);
      chk("fl_count", 32'(count_o),       32'd0);
      chk("fl_index", 32'(alloc_index_o), 32'd0);
      chk("fl_err",   32'(free_err_o),    32'd0);
      chk("fl_empty", 32'(empty_o),       32'd1);

      // Asynchronous reset mid-operation, with an error pulse pending.
      alloc_ready_i = 1'b1;
      tick();
      tick();
      alloc_ready_i = 1'b0;
      free_valid_i  = 1'b1;
      free_index_i  = 2'd3;
      tick();
      free_valid_i = 1'b0;
      chk("ar_pre_err",  32'(free_err_o), 32'd1);
      chk("ar_pre_busy", 32'(busy_o),     32'h3);
      #2 arst_ni = 1'b0;
      #1;
      chk("ar_busy",  32'(busy_o),        32'd0);
      chk("ar_count", 32'(count_o),       32'd0);
      chk("ar_err",   32'(free_err_o),    32'd0);
      chk("ar_valid", 32'(alloc_valid_o), 32'd1);
      chk("ar_index", 32'(alloc_index_o), 32'd0);
      chk("ar_empty", 32'(empty_o),       32'd1);
      #2 arst_ni = 1'b1;
      tick();
      exp_q.push_back(0);
      chk_offer("ar_post");

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Tracks busy/free state of NUM_SLOT resource slots and hands out free slot indices to a consumer over a valid/ready handshake.
- Sits directly upstream of the binary-to-one-hot decoder: alloc_index_o drives the decoder's index input, and the decoder produces per-slot write enables.
- Slot selection is round-robin, searching from one past the last allocated slot, so recently released slots are not reused immediately.
- Released slots come back through a separate free port; a synchronous flush clears all slots.

Parameters:
- NUM_SLOT, 4, number of managed slots; must be >= 2. Under SIMULATION, a value < 2 is a fatal error at time 0.
- IDX_W, $clog2(NUM_SLOT), width of the slot index (derived; do not override).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous clear of all slots.
- alloc_valid_o  output  1  a free slot is offered.
- alloc_index_o  output  IDX_W  offered slot index (feeds the decoder).
- alloc_ready_i  input  1  consumer accepts the offered slot.
- free_valid_i  input  1  release request.
- free_index_i  input  IDX_W  slot being released.
- busy_o  output  NUM_SLOT  per-slot busy bitmap.
- count_o  output  $clog2(NUM_SLOT+1)  number of busy slots.
- full_o  output  1  all slots busy.
- empty_o  output  1  no slot busy.
- free_err_o  output  1  one-cycle pulse: illegal release seen in the previous cycle.

Behaviour:
- Reset (arst_ni low, asynchronous):
  - busy = 0, rr_ptr = 0, count_o = 0, free_err_o = 0.
  - Hence alloc_valid_o = 1, alloc_index_o = 0, empty_o = 1, full_o = 0.
  - Reset may assert mid-operation; all state clears immediately, with no pending effect carried over.
- State registers:
  - busy[NUM_SLOT-1:0]
  - rr_ptr[IDX_W-1:0]
  - count
  - free_err
- Offer logic (combinational from registered state only; no combinational path from any input to the alloc outputs):
  - alloc_index_o = first i with busy[i] == 0, scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_SLOT.
  - alloc_valid_o = ~full_o.
  - When full, alloc_valid_o = 0 and alloc_index_o = 0.
- Allocate: when alloc_valid_o && alloc_ready_i,
  - busy[alloc_index_o] <= 1;
  - rr_ptr <= alloc_index_o + 1, wrapping to 0 past NUM_SLOT-1. NUM_SLOT need not be a power of 2, so wrap explicitly.
  - alloc_ready_i while alloc_valid_o = 0 has no effect.
- Release: when free_valid_i, free_index_i < NUM_SLOT, and busy[free_index_i] == 1,
  - busy[free_index_i] <= 0.
  - A release takes effect the next cycle; the freed slot is never offered in the same cycle it is released.
- Illegal release (slot not busy, or index >= NUM_SLOT):
  - State is unchanged.
  - free_err_o = 1 in the following cycle only.
- Simultaneous allocate and release:
  - Both apply in the same edge; count is unchanged.
  - They never target the same slot, since the offered slot is free and a legal release targets a busy slot.
- count: next = count + alloc_fire - legal_free_fire. count_o = count.
  - full_o = (count == NUM_SLOT).
  - empty_o = (count == 0).
- flush_i (highest priority):
  - busy <= 0, rr_ptr <= 0, count <= 0.
  - Any alloc or free in the same cycle is ignored: no state change and no free_err.
  - alloc_valid_o is still driven during the flush cycle; a consumer handshake in that cycle is discarded by design.
- Invariant: count_o == popcount(busy_o) at all times. Checked by assertion under SIMULATION.

Test Plan:
- Reset, then alloc_ready_i = 1 for 4 cycles (NUM_SLOT = 4) -> alloc_index_o = 0, 1, 2, 3 on consecutive cycles; then full_o = 1, alloc_valid_o = 0, count_o = 4, busy_o = 4'b1111.
- From full, free slot 1, then one alloc -> busy_o = 4'b1101 the cycle after the free; next offer is index 1 (the only free slot); after accept, busy_o = 4'b1111.
- Round-robin: allocate 0 and 1, free 0, then allocate -> offered index is 2 (not 0); rr_ptr wraps so that after 3 the next search starts at 0.
- Same-cycle alloc (offered 2) and free of slot 0 from busy = 4'b0011 -> busy_o = 4'b0110, count_o remains 2.
- Free of non-busy slot 3 with busy = 4'b0001 -> busy_o unchanged, free_err_o = 1 for exactly one cycle.
- flush_i with busy = 4'b1011 plus a simultaneous alloc and free -> next cycle busy_o = 0, count_o = 0, alloc_index_o = 0, free_err_o = 0. Separately, assert arst_ni mid-sequence -> outputs return to reset values immediately, without waiting for a clock edge.
